tiny_mem_unit: RTL and testbench
================================

Name: tiny_mem_unit

Overview:
Parametrised memory-access unit for the multicycle tiny core datapath. It replaces the free-running MAR/MDR register pair with a handshaked access engine. It owns the MAR, the MDR, the address-source mux and the write-data mux. It runs a request/response FSM against variable-latency memory, with a timeout, so control can issue one read or write and wait for a done pulse.

Parameters:
WIDTH, 8, data word width (MDR, data sources, memory data)
AWIDTH, 8, memory address width (MAR)
TIMEOUT, 15, max cycles spent in ACCESS before abort; 0 disables the timeout

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_read  input  1  request a read (sampled only in IDLE)
start_write  input  1  request a write (sampled only in IDLE)
marmux_sel  input  2  address source: 0=rd_val, 1=rs_val, 2=pc_val, 3=imm_addr
rd_val  input  WIDTH  register rd value
rs_val  input  WIDTH  register rs value
pc_val  input  WIDTH  program counter
imm_addr  input  WIDTH  immediate/absolute address
acc_val  input  WIDTH  accumulator (write data)
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with done or standalone (see below)
rdata  output  WIDTH  MDR contents
mem_address  output  AWIDTH  MAR contents
mem_wdata  output  WIDTH  MDR contents (same register as rdata)
mem_read  output  1  read strobe
mem_write  output  1  write strobe
mem_resp  input  1  memory completion, one cycle
mem_rdata  input  WIDTH  read data, valid when mem_resp is high

Behaviour:
- States: IDLE, ACCESS, DONE. Reset (sync, rst=1 at the edge) forces:
  - state=IDLE; MAR=0; MDR=0; timeout counter=0.
  - busy, done, err, mem_read, mem_write all 0.
- Reset wins over every other input, including mid-ACCESS. Strobes are low in the cycle after the reset edge. No done is produced for an aborted access.
- Address formation: take the selected WIDTH-bit source.
  - AWIDTH<=WIDTH: MAR gets its low AWIDTH bits.
  - AWIDTH>WIDTH: MAR gets the source zero-extended.
- IDLE:
  - start_write only: MAR<=mux, MDR<=acc_val, go to ACCESS (write).
  - start_read only: MAR<=mux, MDR unchanged, go to ACCESS (read).
  - Both high: no access; err=1 for one cycle (done=0); stay IDLE.
  - mem_resp in IDLE is ignored.
- ACCESS:
  - mem_read (read) or mem_write (write) is held high continuously. MAR and MDR are stable.
  - The counter increments each cycle in ACCESS.
  - mem_resp=1: a read captures MDR<=mem_rdata; a write leaves MDR unchanged. Go to DONE. Strobes drop in the next cycle.
  - TIMEOUT>0 and counter==TIMEOUT-1 with mem_resp=0: abort. Go to DONE with the error flag set; MDR unchanged.
  - mem_resp arriving on the timeout cycle counts as success.
  - start_read/start_write are ignored while busy.
- DONE: done=1 and busy=1 for exactly one cycle; err=1 here only for a timeout. Counter clears. Return to IDLE.
- Latency: start sampled at edge 0, strobe high from cycle 1, mem_resp in cycle k (k>=1) gives done in cycle k+1. The minimum start-to-done is 2 cycles.
- A new start is accepted in the cycle after DONE (back-to-back issue every 3 cycles minimum).
- Counter width: clog2(TIMEOUT+1), minimum 1. With TIMEOUT=0 the unit waits indefinitely.
- All outputs are registered or decoded from state only; no combinational path from start_* or mem_resp to outputs.

Test Plan:
1. Read, 0-wait: rst, then pc_val=8'h12, marmux_sel=2, start_read. Memory returns mem_resp with mem_rdata=8'hA5 in cycle 1. Required: mem_address=8'h12 and mem_read=1 in cycle 1; done=1, rdata=8'hA5 in cycle 2; busy low in cycle 3.
2. Write, 3-wait: acc_val=8'h3C, rs_val=8'h40, marmux_sel=1, start_write; mem_resp in cycle 4. Required: mem_write high cycles 1-4, mem_wdata=8'h3C, mem_address=8'h40; done in cycle 5; err=0.
3. Timeout: TIMEOUT=4, start_read, mem_resp never arrives. Required: mem_read high cycles 1-4; done=1 and err=1 in cycle 5; rdata keeps its previous value.
4. Conflicts: start_read and start_write together in IDLE gives err pulse, done=0, no strobe. Then start_read followed by start_write asserted during ACCESS: the write is ignored and only one read completes.
5. Reset mid-access: start_write, assert rst in cycle 2. Required: mem_write=0, busy=0, mem_address=0, mem_wdata=0 from cycle 3, with no done pulse. A later stray mem_resp is ignored.
6. Width generality: WIDTH=16, AWIDTH=12, imm_addr=16'hBEEF, marmux_sel=3, read with mem_rdata=16'h1234. Required: mem_address=12'hEEF, rdata=16'h1234.

Source files
------------

// File: rtl/tiny_mem_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_mem_unit_if
//  Description : Variable-latency memory bus between tiny_mem_unit and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tiny_mem_unit_if #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0] mem_address;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic              mem_resp;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        output mem_address,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_address,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_resp,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/tiny_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_mem_unit
//  Description : Handshaked MAR/MDR access engine with timeout for the tiny core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tiny_mem_unit #(
    parameter int WIDTH   = 8,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start_read,
    input  wire logic             start_write,
    input  wire logic [1:0]       marmux_sel,
    input  wire logic [WIDTH-1:0] rd_val,
    input  wire logic [WIDTH-1:0] rs_val,
    input  wire logic [WIDTH-1:0] pc_val,
    input  wire logic [WIDTH-1:0] imm_addr,
    input  wire logic [WIDTH-1:0] acc_val,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WIDTH-1:0]      rdata,
    tiny_mem_unit_if.master       mem
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [AWIDTH-1:0]  r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_write;
    logic               r_err;

    logic [WIDTH-1:0]   w_src;
    logic [AWIDTH-1:0]  w_addr;
    logic               w_timeout;

    always_comb begin
        w_src = rd_val;
        case (marmux_sel)
            2'd0:    w_src = rd_val;
            2'd1:    w_src = rs_val;
            2'd2:    w_src = pc_val;
            default: w_src = imm_addr;
        endcase
    end

    // Narrow address buses keep the low bits; wide ones zero-extend.
    if (AWIDTH < WIDTH) begin : g_addr_trunc
        logic w_unused_hi;
        assign w_addr      = w_src[AWIDTH-1:0];
        assign w_unused_hi = ^w_src[WIDTH-1:AWIDTH];
    end else if (AWIDTH == WIDTH) begin : g_addr_same
        assign w_addr = w_src;
    end else begin : g_addr_zext
        assign w_addr = {{(AWIDTH - WIDTH){1'b0}}, w_src};
    end

    if (TIMEOUT > 0) begin : g_timeout
        localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
        assign w_timeout = (r_cnt == c_CNT_LAST);
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start_read && start_write) begin
                        r_err <= 1'b1;
                    end else if (start_write) begin
                        r_mar      <= w_addr;
                        r_mdr      <= acc_val;
                        r_is_write <= 1'b1;
                        r_state    <= c_ST_ACCESS;
                    end else if (start_read) begin
                        r_mar      <= w_addr;
                        r_is_write <= 1'b0;
                        r_state    <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A response on the final allowed cycle still wins over the abort.
                    if (mem.mem_resp) begin
                        if (!r_is_write) begin
                            r_mdr <= mem.mem_rdata;
                        end
                        r_state <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = (r_state != c_ST_IDLE);
    assign done            = (r_state == c_ST_DONE);
    assign err             = r_err;
    assign rdata           = r_mdr;
    assign mem.mem_address = r_mar;
    assign mem.mem_wdata   = r_mdr;
    assign mem.mem_read    = (r_state == c_ST_ACCESS) && !r_is_write;
    assign mem.mem_write   = (r_state == c_ST_ACCESS) &&  r_is_write;

endmodule
`default_nettype wire

// File: tb/tb_tiny_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiny_mem_unit
//  Description : Directed scoreboard bench for tiny_mem_unit (8/8/4 and 16/12/15).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_mem_unit;

    typedef struct {
        logic        done;
        logic        err;
        logic [15:0] rdata;
        logic [15:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    // DUT A: 8-bit data, 8-bit address, short timeout
    logic       a_start_read = 1'b0, a_start_write = 1'b0;
    logic [1:0] a_sel = 2'd0;
    logic [7:0] a_rd = '0, a_rs = '0, a_pc = '0, a_imm = '0, a_acc = '0;
    logic       a_busy, a_done, a_err;
    logic [7:0] a_rdata;
    tiny_mem_unit_if #(.WIDTH(8), .AWIDTH(8)) a_bus ();

    tiny_mem_unit #(.WIDTH(8), .AWIDTH(8), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .start_read(a_start_read), .start_write(a_start_write),
        .marmux_sel(a_sel),
        .rd_val(a_rd), .rs_val(a_rs), .pc_val(a_pc), .imm_addr(a_imm), .acc_val(a_acc),
        .busy(a_busy), .done(a_done), .err(a_err), .rdata(a_rdata),
        .mem(a_bus.master)
    );

    // DUT B: 16-bit data, 12-bit address
    logic        b_start_read = 1'b0, b_start_write = 1'b0;
    logic [1:0]  b_sel = 2'd0;
    logic [15:0] b_rd = '0, b_rs = '0, b_pc = '0, b_imm = '0, b_acc = '0;
    logic        b_busy, b_done, b_err;
    logic [15:0] b_rdata;
    tiny_mem_unit_if #(.WIDTH(16), .AWIDTH(12)) b_bus ();

    tiny_mem_unit #(.WIDTH(16), .AWIDTH(12), .TIMEOUT(15)) u_dut_b (
        .clk(clk), .rst(rst),
        .start_read(b_start_read), .start_write(b_start_write),
        .marmux_sel(b_sel),
        .rd_val(b_rd), .rs_val(b_rs), .pc_val(b_pc), .imm_addr(b_imm), .acc_val(b_acc),
        .busy(b_busy), .done(b_done), .err(b_err), .rdata(b_rdata),
        .mem(b_bus.master)
    );

    initial begin
        a_bus.mem_resp = 1'b0; a_bus.mem_rdata = '0;
        b_bus.mem_resp = 1'b0; b_bus.mem_rdata = '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitors: pop one expectation per done/err pulse.
    always @(negedge clk) begin
        if (!rst && (a_done || a_err)) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL a_unexpected_resp: got done=%0b err=%0b, expected no response", a_done, a_err);
            end else begin
                e_a = q_a.pop_front();
                check("a_resp_done",  {31'd0, a_done},           {31'd0, e_a.done});
                check("a_resp_err",   {31'd0, a_err},            {31'd0, e_a.err});
                check("a_resp_rdata", {24'd0, a_rdata},          {16'd0, e_a.rdata});
                check("a_resp_addr",  {24'd0, a_bus.mem_address}, {16'd0, e_a.addr});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (b_done || b_err)) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL b_unexpected_resp: got done=%0b err=%0b, expected no response", b_done, b_err);
            end else begin
                e_b = q_b.pop_front();
                check("b_resp_done",  {31'd0, b_done},           {31'd0, e_b.done});
                check("b_resp_err",   {31'd0, b_err},            {31'd0, e_b.err});
                check("b_resp_rdata", {16'd0, b_rdata},          {16'd0, e_b.rdata});
                check("b_resp_addr",  {20'd0, b_bus.mem_address}, {16'd0, e_b.addr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        check("rst_busy",  {31'd0, a_busy}, 32'd0);
        check("rst_done",  {31'd0, a_done}, 32'd0);
        check("rst_err",   {31'd0, a_err}, 32'd0);
        check("rst_rd",    {31'd0, a_bus.mem_read}, 32'd0);
        check("rst_wr",    {31'd0, a_bus.mem_write}, 32'd0);
        check("rst_addr",  {24'd0, a_bus.mem_address}, 32'd0);
        check("rst_rdata", {24'd0, a_rdata}, 32'd0);
        rst = 1'b0;
        step();

        // Read with zero wait states
        a_pc = 8'h12; a_sel = 2'd2; a_start_read = 1'b1;
        q_a.push_back('{done: 1'b1, err: 1'b0, rdata: 16'h00A5, addr: 16'h0012});
        step();
        a_start_read = 1'b0;
        check("t1_addr", {24'd0, a_bus.mem_address}, 32'h12);
        check("t1_read", {31'd0, a_bus.mem_read}, 32'd1);
        a_bus.mem_resp = 1'b1; a_bus.mem_rdata = 8'hA5;
        step();
        a_bus.mem_resp = 1'b0; a_bus.mem_rdata = 8'h00;
        check("t1_done",  {31'd0, a_done}, 32'd1);
        check("t1_rdata", {24'd0, a_rdata}, 32'hA5);
        check("t1_rd_drop", {31'd0, a_bus.mem_read}, 32'd0);
        step();
        check("t1_idle", {31'd0, a_busy}, 32'd0);

        // Write with three wait states; response lands on the last allowed cycle
        a_acc = 8'h3C; a_rs = 8'h40; a_sel = 2'd1; a_start_write = 1'b1;
        q_a.push_back('{done: 1'b1, err: 1'b0, rdata: 16'h003C, addr: 16'h0040});
        for (int c = 1; c <= 4; c++) begin
            step();
            a_start_write = 1'b0;
            check("t2_write", {31'd0, a_bus.mem_write}, 32'd1);
            check("t2_done_lo", {31'd0, a_done}, 32'd0);
            if (c == 4) a_bus.mem_resp = 1'b1;
        end
        check("t2_wdata", {24'd0, a_bus.mem_wdata}, 32'h3C);
        check("t2_addr",  {24'd0, a_bus.mem_address}, 32'h40);
        step();
        a_bus.mem_resp = 1'b0;
        check("t2_done", {31'd0, a_done}, 32'd1);
        check("t2_err",  {31'd0, a_err}, 32'd0);
        check("t2_wr_drop", {31'd0, a_bus.mem_write}, 32'd0);
        step();

        // Timeout: no response ever arrives
        a_rd = 8'h77; a_sel = 2'd0; a_start_read = 1'b1;
        q_a.push_back('{done: 1'b1, err: 1'b1, rdata: 16'h003C, addr: 16'h0077});
        for (int c = 1; c <= 4; c++) begin
            step();
            a_start_read = 1'b0;
            check("t3_read", {31'd0, a_bus.mem_read}, 32'd1);
            check("t3_done_lo", {31'd0, a_done}, 32'd0);
        end
        step();
        check("t3_done",  {31'd0, a_done}, 32'd1);
        check("t3_err",   {31'd0, a_err}, 32'd1);
        check("t3_rdata", {24'd0, a_rdata}, 32'h3C);
        check("t3_rd_drop", {31'd0, a_bus.mem_read}, 32'd0);
        step();
        check("t3_idle", {31'd0, a_busy}, 32'd0);

        // Conflicting starts in IDLE
        a_start_read = 1'b1; a_start_write = 1'b1;
        q_a.push_back('{done: 1'b0, err: 1'b1, rdata: 16'h003C, addr: 16'h0077});
        step();
        a_start_read = 1'b0; a_start_write = 1'b0;
        check("t4_err",  {31'd0, a_err}, 32'd1);
        check("t4_done", {31'd0, a_done}, 32'd0);
        check("t4_busy", {31'd0, a_busy}, 32'd0);
        check("t4_strb", {30'd0, a_bus.mem_read, a_bus.mem_write}, 32'd0);
        step();
        check("t4_err_drop", {31'd0, a_err}, 32'd0);

        // Write request while a read is in flight is ignored
        a_rd = 8'h55; a_sel = 2'd0; a_start_read = 1'b1;
        q_a.push_back('{done: 1'b1, err: 1'b0, rdata: 16'h0099, addr: 16'h0055});
        step();
        a_start_read = 1'b0; a_start_write = 1'b1; a_acc = 8'hEE;
        step();
        a_bus.mem_resp = 1'b1; a_bus.mem_rdata = 8'h99;
        check("t4_no_wr", {31'd0, a_bus.mem_write}, 32'd0);
        step();
        a_bus.mem_resp = 1'b0; a_start_write = 1'b0;
        check("t4_done2", {31'd0, a_done}, 32'd1);
        check("t4_rdata", {24'd0, a_rdata}, 32'h99);
        step();
        check("t4_idle", {31'd0, a_busy}, 32'd0);
        check("t4_no_wr2", {31'd0, a_bus.mem_write}, 32'd0);
        step();

        // Reset in the middle of a write
        a_acc = 8'h81; a_rd = 8'h22; a_sel = 2'd0; a_start_write = 1'b1;
        step();
        a_start_write = 1'b0;
        check("t5_write", {31'd0, a_bus.mem_write}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_wr_lo", {31'd0, a_bus.mem_write}, 32'd0);
        check("t5_busy",  {31'd0, a_busy}, 32'd0);
        check("t5_addr",  {24'd0, a_bus.mem_address}, 32'd0);
        check("t5_wdata", {24'd0, a_bus.mem_wdata}, 32'd0);
        a_bus.mem_resp = 1'b1; a_bus.mem_rdata = 8'h5A;
        step();
        a_bus.mem_resp = 1'b0;
        check("t5_no_done", {31'd0, a_done}, 32'd0);
        check("t5_no_busy", {31'd0, a_busy}, 32'd0);
        step();

        // Wider data with a narrower address bus
        b_imm = 16'hBEEF; b_sel = 2'd3; b_start_read = 1'b1;
        q_b.push_back('{done: 1'b1, err: 1'b0, rdata: 16'h1234, addr: 16'h0EEF});
        step();
        b_start_read = 1'b0;
        check("t6_addr", {20'd0, b_bus.mem_address}, 32'hEEF);
        check("t6_read", {31'd0, b_bus.mem_read}, 32'd1);
        step();
        b_bus.mem_resp = 1'b1; b_bus.mem_rdata = 16'h1234;
        step();
        b_bus.mem_resp = 1'b0;
        check("t6_done",  {31'd0, b_done}, 32'd1);
        check("t6_rdata", {16'd0, b_rdata}, 32'h1234);
        step();
        step();

        check("sb_a_empty", q_a.size(), 32'd0);
        check("sb_b_empty", q_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
